// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types, defaults and helpers for the 16-bit deserializer
package deser_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// rtl/deser_word_fifo.sv - small completed-word FIFO with registered head output
module deser_word_fifo
    import deser_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [WIDTH-1:0] head
);

    localparam int AW = clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop, do_push;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = head_q;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_pop  = pop & ~empty;
        // a pop frees its slot first, so a full FIFO still accepts a same-edge push
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        head_d = (wr_d != rd_d) ? mem_d[rd_d[AW-1:0]] : '0;
        if (clr) begin
            wr_d   = '0;
            rd_d   = '0;
            head_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/deser_16_right_rx.sv
// rtl/deser_16_right_rx.sv - LSB-first serial-to-parallel receiver with word FIFO and sticky flags
module deser_16_right_rx
    import deser_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             Clock,
    input  logic             AclrN,
    input  logic             Sclr,
    input  logic             SerIn,
    input  logic             SerValid,
    input  logic             FrameStart,
    output logic [WIDTH-1:0] Word,
    output logic             WordValid,
    input  logic             WordReady,
    output logic             FrameErr,
    output logic             Overrun,
    input  logic             ClrFlags
);

    localparam int CW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             push, frame_set;
    logic             fifo_full, fifo_empty, fifo_drop;

    assign shifted = {SerIn, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        if (SerValid) begin
            case (state_q)
                IDLE: begin
                    if (FrameStart) begin
                        sreg_d  = shifted;
                        cnt_d   = CW'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    sreg_d = shifted;
                    if (FrameStart) begin
                        // restart: stale partial bits shift out before the word completes
                        frame_set = 1'b1;
                        cnt_d     = CW'(1);
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        frame_err_d = frame_set | (frame_err_q & ~ClrFlags);
        overrun_d   = fifo_drop | (overrun_q & ~ClrFlags);
        if (Sclr) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sreg_d      = '0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge AclrN) begin
        if (!AclrN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    deser_word_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (AclrN),
        .clr       (Sclr),
        .push      (push),
        .push_data (shifted),
        .pop       (WordReady),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .head      (Word)
    );

    assign WordValid = ~fifo_empty;
    assign FrameErr  = frame_err_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_deser_16_right_rx.sv
// tb/tb_deser_16_right_rx.sv - directed self-checking bench for deser_16_right_rx
module tb_deser_16_right_rx;

    logic        Clock = 1'b0;
    logic        AclrN, Sclr, SerIn, SerValid, FrameStart, WordReady, ClrFlags;
    logic [15:0] Word;
    logic        WordValid, FrameErr, Overrun;

    int total = 0;
    int bad   = 0;

    deser_16_right_rx #(.WIDTH(16), .FIFO_DEPTH(2)) dut (
        .Clock      (Clock),
        .AclrN      (AclrN),
        .Sclr       (Sclr),
        .SerIn      (SerIn),
        .SerValid   (SerValid),
        .FrameStart (FrameStart),
        .Word       (Word),
        .WordValid  (WordValid),
        .WordReady  (WordReady),
        .FrameErr   (FrameErr),
        .Overrun    (Overrun),
        .ClrFlags   (ClrFlags)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // starts and ends at a negedge; bits go out LSB first
    task automatic send_bits(input logic [15:0] w, input int n, input bit fs, input int gap);
        for (int i = 0; i < n; i++) begin
            SerIn      = w[i];
            SerValid   = 1'b1;
            FrameStart = fs && (i == 0);
            @(posedge Clock);
            @(negedge Clock);
            SerValid   = 1'b0;
            FrameStart = 1'b0;
            SerIn      = 1'b0;
            repeat (gap) @(negedge Clock);
        end
    endtask

    // last_ready / last_clr are applied only on the edge of the final bit
    task automatic send_word(input logic [15:0] w, input int gap, input bit last_ready, input bit last_clr);
        send_bits(w, 15, 1'b1, gap);
        SerIn      = w[15];
        SerValid   = 1'b1;
        WordReady  = last_ready;
        ClrFlags   = last_clr;
        @(posedge Clock);
        @(negedge Clock);
        SerValid   = 1'b0;
        WordReady  = 1'b0;
        ClrFlags   = 1'b0;
        repeat (gap) @(negedge Clock);
    endtask

    task automatic pop_one();
        WordReady = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        WordReady = 1'b0;
    endtask

    task automatic clr_flags();
        ClrFlags = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        ClrFlags = 1'b0;
    endtask

    initial begin
        AclrN = 1'b0; Sclr = 1'b0; SerIn = 1'b0; SerValid = 1'b0;
        FrameStart = 1'b0; WordReady = 1'b0; ClrFlags = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_word", Word, 16'h0000);
        chk("rst_valid", 16'(WordValid), 16'h0);
        chk("rst_ferr", 16'(FrameErr), 16'h0);
        chk("rst_ovr", 16'(Overrun), 16'h0);
        AclrN = 1'b1;
        @(negedge Clock);

        // basic word and one-clock latency after the 16th bit
        send_bits(16'hA5C3, 15, 1'b1, 0);
        chk("lat_valid_before", 16'(WordValid), 16'h0);
        send_bits(16'h0001, 1, 1'b0, 0);
        chk("basic_valid", 16'(WordValid), 16'h1);
        chk("basic_word", Word, 16'hA5C3);
        @(negedge Clock);
        chk("basic_hold", Word, 16'hA5C3);
        pop_one();
        chk("basic_pop_empty", 16'(WordValid), 16'h0);

        // SerValid toggling every cycle
        send_word(16'hA5C3, 1, 1'b0, 1'b0);
        chk("gap_word", Word, 16'hA5C3);
        chk("gap_valid", 16'(WordValid), 16'h1);
        chk("gap_flags", {14'h0, FrameErr, Overrun}, 16'h0);
        pop_one();

        // aborted frame
        send_bits(16'h007F, 7, 1'b1, 0);
        send_word(16'h0001, 0, 1'b0, 1'b0);
        chk("ferr_set", 16'(FrameErr), 16'h1);
        chk("ferr_word", Word, 16'h0001);
        pop_one();
        chk("ferr_only_one", 16'(WordValid), 16'h0);
        clr_flags();
        chk("ferr_cleared", 16'(FrameErr), 16'h0);

        // overrun with depth 2
        send_word(16'h1111, 0, 1'b0, 1'b0);
        send_word(16'h2222, 0, 1'b0, 1'b0);
        chk("ovr_not_yet", 16'(Overrun), 16'h0);
        send_word(16'h3333, 0, 1'b0, 1'b0);
        chk("ovr_set", 16'(Overrun), 16'h1);
        chk("ovr_head1", Word, 16'h1111);
        pop_one();
        chk("ovr_head2", Word, 16'h2222);
        pop_one();
        chk("ovr_drained", 16'(WordValid), 16'h0);
        clr_flags();
        chk("ovr_cleared", 16'(Overrun), 16'h0);

        // push and pop at the same edge while full
        send_word(16'h4444, 0, 1'b0, 1'b0);
        send_word(16'h5555, 0, 1'b0, 1'b0);
        send_word(16'h6666, 0, 1'b1, 1'b0);
        chk("pp_no_ovr", 16'(Overrun), 16'h0);
        chk("pp_head2", Word, 16'h5555);
        pop_one();
        chk("pp_head3", Word, 16'h6666);
        pop_one();
        chk("pp_drained", 16'(WordValid), 16'h0);

        // set beats clear on the same edge
        send_word(16'hAAAA, 0, 1'b0, 1'b0);
        send_word(16'hBBBB, 0, 1'b0, 1'b0);
        send_word(16'hCCCC, 0, 1'b0, 1'b0);
        chk("win_pre", 16'(Overrun), 16'h1);
        send_word(16'hDDDD, 0, 1'b0, 1'b1);
        chk("win_set_over_clr", 16'(Overrun), 16'h1);
        chk("win_head", Word, 16'hAAAA);

        // async reset mid-word
        send_bits(16'hFFFF, 5, 1'b1, 0);
        #2 AclrN = 1'b0;
        #1;
        chk("arst_word", Word, 16'h0000);
        chk("arst_valid", 16'(WordValid), 16'h0);
        chk("arst_flags", {14'h0, FrameErr, Overrun}, 16'h0);
        @(negedge Clock);
        AclrN = 1'b1;
        send_word(16'h00F0, 0, 1'b0, 1'b0);
        chk("arst_after_word", Word, 16'h00F0);
        chk("arst_after_ferr", 16'(FrameErr), 16'h0);

        // synchronous clear drops buffered words
        Sclr = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Sclr = 1'b0;
        chk("sclr_valid", 16'(WordValid), 16'h0);
        chk("sclr_word", Word, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
